// File: rtl/nop_pkg.sv
// Shared ALU definitions used by the NOP unit: operand width, NOP opcode and
// the legal pipeline depth range.
package nop_pkg;

    localparam int unsigned NOP_WIDTH   = 20;
    localparam int unsigned NOP_LAT_MIN = 1;
    localparam int unsigned NOP_LAT_MAX = 8;
    localparam int unsigned ALU_OP_W    = 5;

    // Opcode that routes an instruction to the NOP unit.
    localparam logic [ALU_OP_W-1:0] ALU_OP_NOP = 5'h00;

    // Elaboration-time guard for the pipeline depth parameter.
    function automatic bit latency_ok(input int unsigned lat);
        return (lat >= NOP_LAT_MIN) && (lat <= NOP_LAT_MAX);
    endfunction

endpackage

// File: rtl/nop_stage.sv
// One NOP pipeline stage: payload + valid register with a hold enable.
// Ports:
//   clk, reset_n   - clock, asynchronous active-low reset
//   en             - 1: capture d/d_valid, 0: hold current contents
//   d, d_valid     - payload and valid bit from the previous stage
//   q, q_valid     - registered payload and valid bit
module nop_stage
    import nop_pkg::*;
#(
    parameter int unsigned WIDTH = NOP_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    // Payload is captured regardless of d_valid; only en gates the update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (en) begin
            q       <= d;
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/nop.sv
// Program-flow NOP unit: passes the operand word through LATENCY register
// stages unchanged and counts retired NOPs (saturating).
// Ports:
//   clk, reset_n   - clock, asynchronous active-low reset
//   data, in_valid - operand word and its valid flag
//   stall          - freeze every stage and the retire counter
//   result         - data delayed by LATENCY non-stalled edges
//   out_valid      - result carries a retired NOP
//   nop_count      - saturating count of retired NOPs
module nop
    import nop_pkg::*;
#(
    parameter int unsigned WIDTH   = NOP_WIDTH,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data,
    input  logic             in_valid,
    input  logic             stall,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic [CNT_W-1:0] nop_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (!latency_ok(LATENCY)) begin : g_bad_latency
        $error("nop: LATENCY must be in 1..8");
    end

    // Index 0 is the input port, index k is the output of stage k-1.
    logic [LATENCY:0][WIDTH-1:0] pipe_data;
    logic [LATENCY:0]            pipe_valid;
    logic                        advance;

    assign advance       = ~stall;
    assign pipe_data[0]  = data;
    assign pipe_valid[0] = in_valid;

    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        nop_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk    (clk),
            .reset_n(reset_n),
            .en     (advance),
            .d      (pipe_data[k]),
            .d_valid(pipe_valid[k]),
            .q      (pipe_data[k+1]),
            .q_valid(pipe_valid[k+1])
        );
    end

    // Outputs come straight from the last stage's flops.
    assign result    = pipe_data[LATENCY];
    assign out_valid = pipe_valid[LATENCY];

    // Retire counter: counts on the edge that moves a valid word out; sticks at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nop_count <= '0;
        end else if (advance && out_valid && (nop_count != CNT_MAX)) begin
            nop_count <= nop_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_nop.sv
// Self-checking bench for nop: three instances (default, 4-bit counter,
// three-stage pipeline) share one stimulus stream and are compared against a
// queue-based reference model plus directed vector tables.
module tb_nop;
    import nop_pkg::*;

    localparam int unsigned W = NOP_WIDTH;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] data;
    logic         in_valid;
    logic         stall;

    logic [W-1:0] res_a, res_b, res_c;
    logic         ov_a, ov_b, ov_c;
    logic [15:0]  cnt_a, cnt_c;
    logic [3:0]   cnt_b;

    always #5 clk = ~clk;

    nop u_a (
        .clk(clk), .reset_n(reset_n), .data(data), .in_valid(in_valid), .stall(stall),
        .result(res_a), .out_valid(ov_a), .nop_count(cnt_a)
    );

    nop #(.WIDTH(W), .LATENCY(1), .CNT_W(4)) u_b (
        .clk(clk), .reset_n(reset_n), .data(data), .in_valid(in_valid), .stall(stall),
        .result(res_b), .out_valid(ov_b), .nop_count(cnt_b)
    );

    nop #(.WIDTH(W), .LATENCY(3), .CNT_W(16)) u_c (
        .clk(clk), .reset_n(reset_n), .data(data), .in_valid(in_valid), .stall(stall),
        .result(res_c), .out_valid(ov_c), .nop_count(cnt_c)
    );

    // Reference model: a FIFO of in-flight words per latency; front = output.
    typedef struct packed {
        logic [W-1:0] d;
        logic         v;
    } word_t;

    word_t       m1[$];
    word_t       m3[$];
    int unsigned c_a, c_b, c_c;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    typedef struct {
        logic [W-1:0] d;
        logic         v;
        logic         s;
        logic [W-1:0] er;
        logic         ev;
        logic [15:0]  ec;
    } vec_t;

    vec_t vecs[10];

    function automatic int unsigned sat_inc(input int unsigned c, input int unsigned max);
        return (c >= max) ? max : c + 1;
    endfunction

    task automatic model_reset();
        m1.delete();
        m3.delete();
        m1.push_back('0);
        repeat (3) m3.push_back('0);
        c_a = 0;
        c_b = 0;
        c_c = 0;
    endtask

    task automatic model_edge();
        word_t w;
        if (reset_n && !stall) begin
            if (m1[0].v) begin
                c_a = sat_inc(c_a, 16'hFFFF);
                c_b = sat_inc(c_b, 15);
            end
            if (m3[0].v) c_c = sat_inc(c_c, 16'hFFFF);
            w.d = data;
            w.v = in_valid;
            void'(m1.pop_front());
            void'(m3.pop_front());
            m1.push_back(w);
            m3.push_back(w);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic check_models(input string tag);
        chk({tag, ".a.result"}, 32'(res_a), 32'(m1[0].d));
        chk({tag, ".a.valid"},  32'(ov_a),  32'(m1[0].v));
        chk({tag, ".a.count"},  32'(cnt_a), c_a);
        chk({tag, ".b.result"}, 32'(res_b), 32'(m1[0].d));
        chk({tag, ".b.valid"},  32'(ov_b),  32'(m1[0].v));
        chk({tag, ".b.count"},  32'(cnt_b), c_b);
        chk({tag, ".c.result"}, 32'(res_c), 32'(m3[0].d));
        chk({tag, ".c.valid"},  32'(ov_c),  32'(m3[0].v));
        chk({tag, ".c.count"},  32'(cnt_c), c_c);
    endtask

    // Advance one clock edge: model follows the pre-edge inputs, outputs sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        // Directed sequence for the default instance; expectations hold after the edge.
        vecs[0] = '{20'h12345, 1'b0, 1'b0, 20'h12345, 1'b0, 16'd0};
        vecs[1] = '{20'hABCDE, 1'b1, 1'b0, 20'hABCDE, 1'b1, 16'd0};
        vecs[2] = '{20'hABCDE, 1'b1, 1'b0, 20'hABCDE, 1'b1, 16'd1};
        vecs[3] = '{20'h00001, 1'b1, 1'b1, 20'hABCDE, 1'b1, 16'd1};
        vecs[4] = '{20'h00001, 1'b1, 1'b1, 20'hABCDE, 1'b1, 16'd1};
        vecs[5] = '{20'h00001, 1'b1, 1'b1, 20'hABCDE, 1'b1, 16'd1};
        vecs[6] = '{20'h00001, 1'b1, 1'b0, 20'h00001, 1'b1, 16'd2};
        vecs[7] = '{20'hFFFFF, 1'b0, 1'b0, 20'hFFFFF, 1'b0, 16'd3};
        vecs[8] = '{20'hFFFFF, 1'b0, 1'b0, 20'hFFFFF, 1'b0, 16'd3};
        vecs[9] = '{20'h00000, 1'b0, 1'b0, 20'h00000, 1'b0, 16'd3};

        reset_n  = 1'b1;
        data     = 20'h12345;
        in_valid = 1'b0;
        stall    = 1'b0;

        // Asynchronous reset at 10 ns for 10 ns.
        #10;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst.a.result", 32'(res_a), 32'h0);
        chk("rst.a.valid",  32'(ov_a),  32'h0);
        chk("rst.a.count",  32'(cnt_a), 32'h0);
        chk("rst.c.result", 32'(res_c), 32'h0);
        chk("rst.c.valid",  32'(ov_c),  32'h0);
        check_models("rst");
        #9;
        reset_n = 1'b1;

        // Table-driven directed vectors.
        for (int i = 0; i < 10; i++) begin
            data     = vecs[i].d;
            in_valid = vecs[i].v;
            stall    = vecs[i].s;
            step();
            chk($sformatf("vec%0d.result", i), 32'(res_a), 32'(vecs[i].er));
            chk($sformatf("vec%0d.valid", i),  32'(ov_a),  32'(vecs[i].ev));
            chk($sformatf("vec%0d.count", i),  32'(cnt_a), 32'(vecs[i].ec));
            check_models("vec");
        end

        // Saturation: 20 back-to-back valid words.
        in_valid = 1'b1;
        stall    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            data = W'($urandom);
            step();
            check_models("sat");
        end
        chk("sat.b.count", 32'(cnt_b), 32'hF);

        // Three-stage pipeline: single word pulses out_valid exactly on edge 3.
        in_valid = 1'b0;
        repeat (4) begin
            step();
            check_models("flush");
        end
        data     = 20'h5A5A5;
        in_valid = 1'b1;
        step();
        chk("lat3.e1.valid", 32'(ov_c), 32'h0);
        data     = '0;
        in_valid = 1'b0;
        for (int e = 2; e <= 5; e++) begin
            step();
            chk($sformatf("lat3.e%0d.valid", e), 32'(ov_c), (e == 3) ? 32'h1 : 32'h0);
            if (e == 3) chk("lat3.e3.result", 32'(res_c), 32'h5A5A5);
            check_models("lat3");
        end

        // Reset mid-flight discards the in-flight word.
        data     = 20'h5A5A5;
        in_valid = 1'b1;
        step();
        data     = '0;
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("midrst.c.result", 32'(res_c), 32'h0);
        chk("midrst.c.valid",  32'(ov_c),  32'h0);
        chk("midrst.c.count",  32'(cnt_c), 32'h0);
        #10;
        reset_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
            chk($sformatf("midrst.e%0d.valid", e), 32'(ov_c), 32'h0);
            check_models("midrst");
        end

        // Randomized stimulus with occasional async reset (sometimes alongside stall).
        for (int i = 0; i < 400; i++) begin
            data     = W'($urandom);
            in_valid = ($urandom_range(0, 9) < 7);
            stall    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) begin
                #2;
                reset_n = 1'b0;
                model_reset();
                #1;
                check_models("rand.rst");
                #3;
                reset_n = 1'b1;
            end
            step();
            check_models("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/nop.md
# nop

Program-flow NOP unit of the UrCPU ALU. It passes the 20-bit operand word through unchanged to `result`, over a configurable number of register stages (default 1). This lets the NOP act as a timed delay slot in the instruction flow. It also counts completed NOPs for debug/perf visibility.

## Interface
- `WIDTH`, 20: data/result width in bits.
- `LATENCY`, 1: number of register stages from `data` to `result`; legal 1..8.
- `CNT_W`, 16: width of the retired-NOP counter.

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `data` input WIDTH: operand word to pass through.
- `in_valid` input 1: `data` is a valid NOP operand this cycle.
- `stall` input 1: freeze the pipeline; hold all stage contents and outputs.
- `result` output WIDTH: `data` delayed by `LATENCY` cycles, bit-exact.
- `out_valid` output 1: `result` carries a retired NOP this cycle.
- `nop_count` output CNT_W: saturating count of retired NOPs.

## Operation
- No arithmetic is performed: `result` equals the captured `data` with no modification, sign change or width change.
- Each stage holds a payload (WIDTH) and a valid bit. Stage 0 captures `data`/`in_valid`; stage k captures stage k-1. The last stage drives `result`/`out_valid`.
- Payload is captured regardless of `in_valid`, so `result` tracks `data` even with `in_valid`=0. Only the valid bit gates counting.
- `stall`=1: no stage updates and `nop_count` does not change. `stall` takes priority over new input.
- `nop_count` increments by 1 on each cycle where `out_valid`=1 and `stall`=0. It saturates at all-ones and does not wrap.
- Reset (`reset_n`=0, any time, asynchronous): all stage payloads = 0, all valid bits = 0, `result`=0, `out_valid`=0, `nop_count`=0. Reset mid-flight discards in-flight words.
- Reset release: normal capture resumes on the first rising edge with `reset_n`=1.

## Timing
- Latency is exactly `LATENCY` clock edges from `data` sampled to `result` updated, excluding stalled cycles.
- Throughput is one word per cycle; there is no bubble between back-to-back valid inputs.
- `result` and `out_valid` are registered outputs with no combinational path from inputs.
- `nop_count` updates on the same edge that retires the word, i.e. it is visible one cycle after `out_valid`=1.
- Simultaneous `stall` and reset: reset wins.

## Structure
- Shared ALU package: `NOP_WIDTH`=20 and an opcode constant for NOP.
- A single sub-module, `nop_stage` (payload + valid register with stall enable and async reset), instantiated `LATENCY` times via generate.
- Saturating counter logic stays inline in `nop`.

## Test plan
- Reset: `reset_n`=0 at t=10 ns for 10 ns with `data`=0x12345 -> `result`=0, `out_valid`=0, `nop_count`=0 while asserted. After release, `result`=0x12345 on the first edge.
- Data change: `data` switches 0x12345 -> 0xABCDE with `in_valid`=1 -> `result`=0xABCDE exactly `LATENCY` edges later; `nop_count` increments once per valid cycle.
- Stall: hold `stall`=1 for 3 cycles while `data` changes to 0x00001 -> `result`, `out_valid` and `nop_count` are frozen; the update resumes `LATENCY` edges after `stall` drops.
- Invalid input: `in_valid`=0 with `data`=0xFFFFF -> `result`=0xFFFFF after latency, `out_valid`=0, `nop_count` unchanged.
- Saturation (`CNT_W`=4): 20 back-to-back valid words -> `nop_count` stops at 0xF.
- `LATENCY`=3: single valid word 0x5A5A5 -> `out_valid` pulses for one cycle exactly 3 edges after capture; reset asserted mid-flight clears it and no pulse appears.
